// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: 4-digit multiplexed 7-seg scan with per-frame snapshot, blink, and optional LEADING_ZERO_BLANK_EN
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_min,
  input  logic [3:0] digit_tens,
  input  logic [3:0] digit_ones,
  input  logic [3:0] digit_tenths,
  input  logic       flash,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int SW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          phase, load_pend;
  logic [3:0]    snap_min, snap_tens, snap_ones, snap_tenths;
  logic          tick, frame_tick, lz, blank;
  logic [3:0]    cur;
  logic [6:0]    dec;

  assign tick       = slot_cnt == SW'(REFRESH_DIV - 1);
  assign frame_tick = tick && idx == 2'd3;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'h40;
      4'd1: dec7 = 7'h79;
      4'd2: dec7 = 7'h24;
      4'd3: dec7 = 7'h30;
      4'd4: dec7 = 7'h19;
      4'd5: dec7 = 7'h12;
      4'd6: dec7 = 7'h02;
      4'd7: dec7 = 7'h78;
      4'd8: dec7 = 7'h00;
      4'd9: dec7 = 7'h10;
      default: dec7 = 7'h3F;
    endcase
  endfunction

  // slot timer and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= 2'd0;
    end else begin
      slot_cnt <= tick ? '0 : slot_cnt + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  // latch all four digits together so a frame never mixes old and new values
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_min    <= '0;
      snap_tens   <= '0;
      snap_ones   <= '0;
      snap_tenths <= '0;
      load_pend   <= 1'b1;
    end else begin
      if (frame_tick || load_pend) begin
        snap_min    <= digit_min;
        snap_tens   <= digit_tens;
        snap_ones   <= digit_ones;
        snap_tenths <= digit_tenths;
      end
      load_pend <= 1'b0;
    end
  end

  // blink cadence; dropping flash clears immediately so the next flash starts visible
  always_ff @(posedge clk) begin
    if (reset || !flash) begin
      phase     <= 1'b0;
      blink_cnt <= '0;
    end else if (frame_tick) begin
      phase     <= blink_cnt == BW'(BLINK_DIV - 1) ? ~phase : phase;
      blink_cnt <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign lz = idx == 2'd0 && snap_min == 4'd0;
`else
  assign lz = 1'b0;
`endif

  // nothing valid to show until the first snapshot has been taken
  assign blank = phase | load_pend | lz;
  assign cur   = idx == 2'd0 ? snap_min : idx == 2'd1 ? snap_tens : idx == 2'd2 ? snap_ones : snap_tenths;
  assign dec   = dec7(cur);

  // registered drive of anodes, segments and decimal point
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= blank ? 4'b1111 : ~(4'b1000 >> idx);
      seg <= blank ? 7'h7F : dec;
      dp  <= blank | idx[0];
    end
  end
endmodule
